// File: rtl/div_sweeper.sv
// div_sweeper: exhaustive stimulus sequencer for two divider units.
//
// A go pulse starts a sweep over every {dividend, divisor} pair, with the
// divisor in the low field and the dividend in the high field. For each pair
// the block issues one strt pulse, waits for both dividers to report idle
// (bounded by TIMEOUT cycles), and then compares the two result sets. It
// counts failing pairs (saturating) and captures the first failing pair.
//
// Optional feature: define DIV_SWEEP_GOLDEN_EN to also check divider A
// against an internal golden divide model.
//
// Parameters:
//   WIDTH   operand width; a sweep covers 2^(2*WIDTH) pairs
//   TIMEOUT maximum WAIT cycles before a pair is declared failed
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   go                        single-cycle sweep start (ignored while busy)
//   dividend, divisor         operands to both dividers
//   strt                      single-cycle start pulse to both dividers
//   quotient_a/_b, remainder_a/_b, not_valid_a/_b, idle_a/_b  divider status
//   busy, done, fail          sweep status
//   mismatch_count            failing pairs, saturates at 16'hFFFF
//   first_fail                {dividend, divisor} of the first failing pair
//   state_dbg                 current FSM state encoding
//
// Handshake: strt is a one-cycle pulse; a divider may keep idle high for
// that cycle and is expected to drop it no earlier than the next one, so
// idle is ignored for one GUARD cycle. Results are sampled in the cycle in
// which idle_a & idle_b is seen high (or on timeout, which fails the pair).

module div_sweeper #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  output logic [WIDTH-1:0]     dividend,
  output logic [WIDTH-1:0]     divisor,
  output logic                 strt,
  input  logic [WIDTH-1:0]     quotient_a,
  input  logic [WIDTH-1:0]     remainder_a,
  input  logic                 not_valid_a,
  input  logic                 idle_a,
  input  logic [WIDTH-1:0]     quotient_b,
  input  logic [WIDTH-1:0]     remainder_b,
  input  logic                 not_valid_b,
  input  logic                 idle_b,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [15:0]          mismatch_count,
  output logic [2*WIDTH-1:0]   first_fail,
  output logic [2:0]           state_dbg
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    GUARD = 3'd2,
    WAIT  = 3'd3,
    CHECK = 3'd4,
    NEXT  = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t              state, next_state;
  logic [2*WIDTH-1:0]  pair;
  logic [TW-1:0]       tcnt;
  logic                tflag;
  logic                both_idle;
  logic                ab_bad;
  logic                gold_bad;
  logic                pair_bad;

  // The pair counter is itself a register, so the operands are registered
  // and hold from ISSUE through CHECK without extra storage.
  assign dividend  = pair[2*WIDTH-1:WIDTH];
  assign divisor   = pair[WIDTH-1:0];
  assign state_dbg = state;
  assign both_idle = idle_a & idle_b;

  always_comb begin
    ab_bad = 1'b0;
    if (not_valid_a != not_valid_b) begin
      ab_bad = 1'b1;
    end else if (!not_valid_a) begin
      ab_bad = (quotient_a != quotient_b) || (remainder_a != remainder_b);
    end
  end

`ifdef DIV_SWEEP_GOLDEN_EN
  always_comb begin
    gold_bad = 1'b0;
    if (divisor == '0) begin
      gold_bad = !not_valid_a;
    end else begin
      gold_bad = not_valid_a ||
                 (quotient_a  != dividend / divisor) ||
                 (remainder_a != dividend % divisor);
    end
  end
`else
  assign gold_bad = 1'b0;
`endif

  assign pair_bad = tflag | ab_bad | gold_bad;

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (go) next_state = ISSUE;
      ISSUE:      next_state = GUARD;
      GUARD:      next_state = WAIT;
      WAIT:       if (both_idle || tcnt == T_LAST) next_state = CHECK;
      CHECK:      next_state = NEXT;
      NEXT:       next_state = (pair == '1) ? DONE : ISSUE;
      default:    next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      pair           <= '0;
      tcnt           <= '0;
      tflag          <= 1'b0;
      strt           <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      fail           <= 1'b0;
      mismatch_count <= '0;
      first_fail     <= '0;
    end else begin
      state <= next_state;
      // strt is high in the cycle after ISSUE, i.e. while in GUARD.
      strt  <= (state == ISSUE);
      busy  <= !(next_state == IDLE || next_state == DONE);
      done  <= (next_state == DONE);
      case (state)
        IDLE, DONE: begin
          if (go) begin
            fail           <= 1'b0;
            mismatch_count <= '0;
            first_fail     <= '0;
            pair           <= '0;
          end
        end
        GUARD: begin
          tcnt  <= '0;
          tflag <= 1'b0;
        end
        WAIT: begin
          // Idle wins on the final cycle: a late but valid finish is not a timeout.
          if (!both_idle) begin
            if (tcnt == T_LAST) tflag <= 1'b1;
            else                tcnt  <= tcnt + 1'b1;
          end
        end
        CHECK: begin
          if (pair_bad) begin
            if (mismatch_count != 16'hFFFF) mismatch_count <= mismatch_count + 16'd1;
            if (!fail) begin
              first_fail <= pair;
              fail       <= 1'b1;
            end
          end
        end
        NEXT: begin
          if (pair != '1) pair <= pair + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sweeper.sv
// Directed testbench for div_sweeper at WIDTH=4, TIMEOUT=8, with two
// behavioural dividers whose faults are switched on per sweep.
module tb_div_sweeper;

  localparam int W  = 4;
  localparam int TO = 8;
  localparam logic [2:0] WAIT_ST = 3'd3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         go  = 1'b0;
  logic [W-1:0] dividend, divisor;
  logic         strt, busy, done, fail;
  logic [W-1:0] quotient_a = '0, remainder_a = '0, quotient_b = '0, remainder_b = '0;
  logic         not_valid_a = 1'b0, not_valid_b = 1'b0;
  logic         idle_a = 1'b1, idle_b = 1'b1;
  logic [15:0]  mismatch_count;
  logic [2*W-1:0] first_fail;
  logic [2:0]   state_dbg;

  // fault / behaviour switches for the divider models
  logic fast = 1'b0, corrupt_b = 1'b0, hang_b = 1'b0, wrong_both = 1'b0;

  int total = 0;
  int bad   = 0;
  int strt_total = 0, strt_double = 0, wait_total = 0, wait_div0 = 0;
  logic strt_prev = 1'b0;

  always #5 clk = ~clk;

  div_sweeper #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .go(go),
    .dividend(dividend), .divisor(divisor), .strt(strt),
    .quotient_a(quotient_a), .remainder_a(remainder_a),
    .not_valid_a(not_valid_a), .idle_a(idle_a),
    .quotient_b(quotient_b), .remainder_b(remainder_b),
    .not_valid_b(not_valid_b), .idle_b(idle_b),
    .busy(busy), .done(done), .fail(fail),
    .mismatch_count(mismatch_count), .first_fail(first_fail),
    .state_dbg(state_dbg)
  );

  // Reference divide: {not_valid, quotient, remainder}; zero divisor gives q=all-ones.
  function automatic logic [2*W:0] ref_div(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic unit_b);
    logic [W-1:0] q, r;
    if (y == '0) return {1'b1, {W{1'b1}}, x};
    q = x / y;
    r = x % y;
    if (wrong_both && x == 4'd7 && y == 4'd3) q = q ^ 4'd1;
    if (unit_b && corrupt_b && x == 4'd9 && y == 4'd2) q = q ^ 4'd1;
    return {1'b0, q, r};
  endfunction

  logic [W-1:0] opx_a, opy_a, opx_b, opy_b;
  logic [1:0]   cnt_a = '0, cnt_b = '0;

  always @(posedge clk) begin
    if (strt) begin
      if (fast) begin
        {not_valid_a, quotient_a, remainder_a} <= ref_div(dividend, divisor, 1'b0);
      end else begin
        idle_a <= 1'b0; cnt_a <= 2'd2; opx_a <= dividend; opy_a <= divisor;
      end
    end else if (!idle_a) begin
      if (cnt_a == 2'd0) begin
        idle_a <= 1'b1;
        {not_valid_a, quotient_a, remainder_a} <= ref_div(opx_a, opy_a, 1'b0);
      end else cnt_a <= cnt_a - 2'd1;
    end
  end

  always @(posedge clk) begin
    if (strt) begin
      if (fast) begin
        {not_valid_b, quotient_b, remainder_b} <= ref_div(dividend, divisor, 1'b1);
      end else begin
        idle_b <= 1'b0; cnt_b <= 2'd2; opx_b <= dividend; opy_b <= divisor;
      end
    end else if (!idle_b) begin
      if (cnt_b == 2'd0) begin
        if (!(hang_b && opy_b == '0)) begin
          idle_b <= 1'b1;
          {not_valid_b, quotient_b, remainder_b} <= ref_div(opx_b, opy_b, 1'b1);
        end
      end else cnt_b <= cnt_b - 2'd1;
    end
  end

  // passive monitor of strt pulses and WAIT occupancy
  always @(negedge clk) begin
    if (strt) begin
      strt_total <= strt_total + 1;
      if (strt_prev) strt_double <= strt_double + 1;
    end
    strt_prev <= strt;
    if (state_dbg == WAIT_ST) begin
      wait_total <= wait_total + 1;
      if (divisor == '0) wait_div0 <= wait_div0 + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_go();
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  int s0, d0, w0, z0;

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    check("rst_strt",  {31'd0, strt}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_fail",  {31'd0, fail}, 32'd0);
    check("rst_ops",   {24'd0, dividend, divisor}, 32'd0);
    check("rst_count", {16'd0, mismatch_count}, 32'd0);
    check("rst_ff",    {24'd0, first_fail}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, 32'd0);
    rst = 1'b1;

    // sweep 1: matching dividers, go latency, extra go while busy ignored
    @(negedge clk); s0 = strt_total; d0 = strt_double;
    go = 1'b1;
    @(posedge clk); #1;
    check("lat_strt0", {31'd0, strt}, 32'd0);
    check("lat_busy",  {31'd0, busy}, 32'd1);
    @(negedge clk); go = 1'b0;
    @(posedge clk); #1;
    check("lat_strt1", {31'd0, strt}, 32'd1);
    check("lat_ops",   {24'd0, dividend, divisor}, 32'd0);
    repeat (30) @(negedge clk);
    pulse_go();
    repeat (50) @(negedge clk);
    pulse_go();
    wait_done("s1");
    check("s1_fail",   {31'd0, fail}, 32'd0);
    check("s1_count",  {16'd0, mismatch_count}, 32'd0);
    check("s1_busy",   {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    check("s1_strts",  strt_total - s0, 32'd256);
    check("s1_double", strt_double - d0, 32'd0);
    check("s1_hold",   {31'd0, done}, 32'd1);

    // sweep 2: divider B corrupts 9/2 only
    corrupt_b = 1'b1;
    pulse_go();
    check("s2_cleared", {31'd0, done}, 32'd0);
    wait_done("s2");
    check("s2_count", {16'd0, mismatch_count}, 32'd1);
    check("s2_fail",  {31'd0, fail}, 32'd1);
    check("s2_ff",    {24'd0, first_fail}, 32'h92);
    corrupt_b = 1'b0;

    // sweep 3: divider B hangs on divisor 0 -> 16 timeouts of TO cycles each
    hang_b = 1'b1;
    @(negedge clk); z0 = wait_div0;
    pulse_go();
    wait_done("s3");
    check("s3_count", {16'd0, mismatch_count}, 32'd16);
    check("s3_ff",    {24'd0, first_fail}, 32'h00);
    repeat (2) @(negedge clk);
    check("s3_wait0", wait_div0 - z0, 32'(16 * TO));
    hang_b = 1'b0;

    // sweep 4: both dividers wrong identically for 7/3
    wrong_both = 1'b1;
    pulse_go();
    wait_done("s4");
`ifdef DIV_SWEEP_GOLDEN_EN
    check("s4_count", {16'd0, mismatch_count}, 32'd1);
    check("s4_ff",    {24'd0, first_fail}, 32'h73);
`else
    check("s4_count", {16'd0, mismatch_count}, 32'd0);
    check("s4_fail",  {31'd0, fail}, 32'd0);
`endif
    wrong_both = 1'b0;

    // sweep 5: dividers that never leave idle -> one WAIT cycle per pair
    fast = 1'b1;
    @(negedge clk); w0 = wait_total;
    pulse_go();
    wait_done("s5");
    check("s5_fail", {31'd0, fail}, 32'd0);
    repeat (2) @(negedge clk);
    check("s5_waits", wait_total - w0, 32'd256);
    fast = 1'b0;

    // reset during WAIT of pair 40 (0x28)
    pulse_go();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (state_dbg == WAIT_ST && dividend == 4'd2 && divisor == 4'd8) break;
    end
    check("mid_reached", {29'd0, state_dbg}, {29'd0, WAIT_ST});
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_strt",  {31'd0, strt}, 32'd0);
    check("mid_busy",  {31'd0, busy}, 32'd0);
    check("mid_done",  {31'd0, done}, 32'd0);
    check("mid_ops",   {24'd0, dividend, divisor}, 32'd0);
    check("mid_state", {29'd0, state_dbg}, 32'd0);
    check("mid_count", {16'd0, mismatch_count}, 32'd0);
    @(negedge clk); rst = 1'b1;
    repeat (10) @(negedge clk);
    pulse_go();
    for (int i = 0; i < 10; i++) begin
      if (strt) break;
      @(negedge clk);
    end
    check("restart_strt", {31'd0, strt}, 32'd1);
    check("restart_ops",  {24'd0, dividend, divisor}, 32'd0);
    wait_done("s6");
    check("s6_count", {16'd0, mismatch_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
